// File: rtl/sdram_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sdram_sched_pkg
//  Purpose : Shared types and helpers for the SDRAM multi-port burst
//            scheduler: FSM state encoding, index-width function and a
//            field extractor for the flattened per-port vectors.
//  Ports   : none (package)
//  Rev     : 1.0  initial multi-port release
// ============================================================================
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } sched_state_t;

    // Flattened per-port vectors are widened to this before slicing; it
    // covers 8 ports of up to 64-bit fields.
    localparam int c_VEC_MAX   = 512;
    localparam int c_FIELD_MAX = 32;

    // Index width for an N-entry selector; never returns 0 so N=1 still
    // yields a legal 1-bit vector.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Returns field idx of a vector made of width-bit fields packed from
    // bit 0 upwards (port 0 in the LSBs). Callers truncate to the field width.
    function automatic logic [c_FIELD_MAX-1:0] field_get(
        input logic [c_VEC_MAX-1:0] vec,
        input int                   idx,
        input int                   width
    );
        logic [c_VEC_MAX-1:0] sh;
        sh = vec >> (idx * width);
        return sh[c_FIELD_MAX-1:0] & ((c_FIELD_MAX'(1) << width) - c_FIELD_MAX'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module  : sdram_port_scheduler_if
//  Purpose : Request/ack/done handshake between the port scheduler and the
//            SDRAM burst engine.
//  Ports   : REQ, REQ_WRITE, REQ_ADDR, REQ_LEN  scheduler -> engine
//            REQ_ACK, BURST_DONE                engine -> scheduler
//  Rev     : 1.0  initial multi-port release
// ============================================================================
interface sdram_port_scheduler_if #(
    parameter int ASIZE = 22,
    parameter int LSIZE = 9
) ();
    logic             REQ;
    logic             REQ_WRITE;
    logic [ASIZE-1:0] REQ_ADDR;
    logic [LSIZE-1:0] REQ_LEN;
    logic             REQ_ACK;
    logic             BURST_DONE;

    modport master (
        output REQ, REQ_WRITE, REQ_ADDR, REQ_LEN,
        input  REQ_ACK, BURST_DONE
    );

    modport slave (
        input  REQ, REQ_WRITE, REQ_ADDR, REQ_LEN,
        output REQ_ACK, BURST_DONE
    );
endinterface
`default_nettype wire

// File: rtl/sdram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : sdram_rr_arbiter
//  Purpose : N-way round-robin arbiter. Search starts at the entry after the
//            last granted one; the pointer moves only when i_adv is high.
//  Ports   : CLK, RESET_N     clock, async active-low reset
//            i_req [N]        request vector
//            i_adv            commit the current grant (advance pointer)
//            o_gnt [N]        one-hot grant (combinational)
//            o_any            at least one request present
//  Rev     : 1.0  initial multi-port release
// ============================================================================
module sdram_rr_arbiter
    import sdram_sched_pkg::*;
#(
    parameter int N = 2
) (
    input  wire logic         CLK,
    input  wire logic         RESET_N,
    input  wire logic [N-1:0] i_req,
    input  wire logic         i_adv,
    output logic      [N-1:0] o_gnt,
    output logic              o_any
);
    localparam int c_IW = clog2(N);

    logic [c_IW-1:0] r_last;
    logic [c_IW-1:0] w_idx;
    logic [N-1:0]    w_gnt;
    logic            w_any;

    // Candidate k (1..N) is (last + k) mod N, so the last winner is
    // searched last.
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_any && (j == (int'(r_last) + k) % N) && i_req[j]) begin
                    w_any    = 1'b1;
                    w_gnt[j] = 1'b1;
                    w_idx    = c_IW'(j);
                end
            end
        end
    end

    // Reset to N-1 so the first search begins at entry 0.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_last <= c_IW'(N - 1);
        end else if (i_adv && w_any) begin
            r_last <= w_idx;
        end
    end

    assign o_gnt = w_gnt;
    assign o_any = w_any;

endmodule
`default_nettype wire

// File: rtl/sdram_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : sdram_port_scheduler
//  Purpose : Chooses the next SDRAM burst among NWR write and NRD read ports.
//            Writes beat reads; round-robin inside each class. Each port
//            walks an address window and reports wrap-around.
//  Ports   : CLK, RESET_N                       clock, async active-low reset
//            WR_/RD_START_ADDR, _MAX_ADDR       per-port window [start, max)
//            WR_/RD_LENGTH, WR_/RD_LOAD         per-port burst length / load
//            WR_LEVEL / RD_LEVEL                FIFO fill levels
//            ENG                                burst engine handshake
//            WR_SEL / RD_SEL                    one-hot FIFO gating
//            WRAP                               per-port wrap pulse
//                                               ([NWR-1:0] write, rest read)
//  Rev     : 1.0  initial multi-port release
// ============================================================================
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int NWR        = 2,
    parameter int NRD        = 2,
    parameter int ASIZE      = 22,
    parameter int LSIZE      = 9,
    parameter int UWIDTH     = 9,
    parameter int FIFO_DEPTH = 512
) (
    input  wire logic                  CLK,
    input  wire logic                  RESET_N,
    input  wire logic [NWR*ASIZE-1:0]  WR_START_ADDR,
    input  wire logic [NWR*ASIZE-1:0]  WR_MAX_ADDR,
    input  wire logic [NWR*LSIZE-1:0]  WR_LENGTH,
    input  wire logic [NWR-1:0]        WR_LOAD,
    input  wire logic [NWR*UWIDTH-1:0] WR_LEVEL,
    input  wire logic [NRD*ASIZE-1:0]  RD_START_ADDR,
    input  wire logic [NRD*ASIZE-1:0]  RD_MAX_ADDR,
    input  wire logic [NRD*LSIZE-1:0]  RD_LENGTH,
    input  wire logic [NRD-1:0]        RD_LOAD,
    input  wire logic [NRD*UWIDTH-1:0] RD_LEVEL,
    output logic      [NWR-1:0]        WR_SEL,
    output logic      [NRD-1:0]        RD_SEL,
    output logic      [NWR+NRD-1:0]    WRAP,
    sdram_port_scheduler_if.master     ENG
);
    localparam int c_UW1 = UWIDTH + 1;

    sched_state_t r_state, w_state_nxt;

    logic [ASIZE-1:0] w_wr_addr [NWR];
    logic [LSIZE-1:0] w_wr_len  [NWR];
    logic [ASIZE-1:0] w_rd_addr [NRD];
    logic [LSIZE-1:0] w_rd_len  [NRD];
    logic [NWR-1:0]   w_wr_elig, w_wr_gnt, w_wr_wrap;
    logic [NRD-1:0]   w_rd_elig, w_rd_gnt, w_rd_wrap;
    logic             w_wr_any, w_rd_any;
    logic             w_grant_ok, w_grant, w_done;
    logic [ASIZE-1:0] w_gnt_addr;
    logic [LSIZE-1:0] w_gnt_len;

    logic             r_post;
    logic             r_req_write;
    logic [ASIZE-1:0] r_req_addr;
    logic [LSIZE-1:0] r_req_len;
    logic [NWR-1:0]   r_wr_sel;
    logic [NRD-1:0]   r_rd_sel;

    // The cycle after BURST_DONE is reserved for the address update, so it
    // never grants; this also guarantees one idle cycle between bursts.
    assign w_grant_ok = (r_state == ST_IDLE) && !r_post;
    assign w_grant    = w_grant_ok && (w_wr_any || w_rd_any);
    assign w_done     = (r_state == ST_BUSY) && ENG.BURST_DONE;

    // ------------------------------------------------------------------
    // Write ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NWR; p++) begin : g_wr_port
        logic [ASIZE-1:0]  w_start, w_max;
        logic [LSIZE-1:0]  w_length;
        logic [UWIDTH-1:0] w_level;
        logic [ASIZE:0]    w_next;
        logic [ASIZE-1:0]  r_addr;
        logic [LSIZE-1:0]  r_len;
        logic              r_wrap;

        assign w_start  = ASIZE'(field_get(c_VEC_MAX'(WR_START_ADDR), p, ASIZE));
        assign w_max    = ASIZE'(field_get(c_VEC_MAX'(WR_MAX_ADDR), p, ASIZE));
        assign w_length = LSIZE'(field_get(c_VEC_MAX'(WR_LENGTH), p, LSIZE));
        assign w_level  = UWIDTH'(field_get(c_VEC_MAX'(WR_LEVEL), p, UWIDTH));
        assign w_next   = {1'b0, r_addr} + (ASIZE+1)'(r_len);

        assign w_wr_elig[p] = (r_len != '0) && !WR_LOAD[p] &&
                              (32'(w_level) >= 32'(r_len));

        // LOAD takes precedence over the end-of-burst update.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_addr <= '0;
                r_len  <= '0;
                r_wrap <= 1'b0;
            end else begin
                r_wrap <= 1'b0;
                if (WR_LOAD[p]) begin
                    r_addr <= w_start;
                    r_len  <= w_length;
                end else if (w_done && r_wr_sel[p]) begin
                    if (w_next < {1'b0, w_max}) begin
                        r_addr <= w_next[ASIZE-1:0];
                    end else begin
                        r_addr <= w_start;
                        r_wrap <= 1'b1;
                    end
                end
            end
        end

        assign w_wr_addr[p] = r_addr;
        assign w_wr_len[p]  = r_len;
        assign w_wr_wrap[p] = r_wrap;
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar q = 0; q < NRD; q++) begin : g_rd_port
        logic [ASIZE-1:0]  w_start, w_max;
        logic [LSIZE-1:0]  w_length;
        logic [UWIDTH-1:0] w_level;
        logic [c_UW1-1:0]  w_fill;
        logic [ASIZE:0]    w_next;
        logic [ASIZE-1:0]  r_addr;
        logic [LSIZE-1:0]  r_len;
        logic              r_wrap;

        assign w_start  = ASIZE'(field_get(c_VEC_MAX'(RD_START_ADDR), q, ASIZE));
        assign w_max    = ASIZE'(field_get(c_VEC_MAX'(RD_MAX_ADDR), q, ASIZE));
        assign w_length = LSIZE'(field_get(c_VEC_MAX'(RD_LENGTH), q, LSIZE));
        assign w_level  = UWIDTH'(field_get(c_VEC_MAX'(RD_LEVEL), q, UWIDTH));
        assign w_next   = {1'b0, r_addr} + (ASIZE+1)'(r_len);

        // One extra bit so level + length cannot overflow before comparing
        // against the FIFO depth.
        assign w_fill = c_UW1'(w_level) + c_UW1'(r_len);

        assign w_rd_elig[q] = (r_len != '0) && !RD_LOAD[q] &&
                              (w_fill <= c_UW1'(FIFO_DEPTH));

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_addr <= '0;
                r_len  <= '0;
                r_wrap <= 1'b0;
            end else begin
                r_wrap <= 1'b0;
                if (RD_LOAD[q]) begin
                    r_addr <= w_start;
                    r_len  <= w_length;
                end else if (w_done && r_rd_sel[q]) begin
                    if (w_next < {1'b0, w_max}) begin
                        r_addr <= w_next[ASIZE-1:0];
                    end else begin
                        r_addr <= w_start;
                        r_wrap <= 1'b1;
                    end
                end
            end
        end

        assign w_rd_addr[q] = r_addr;
        assign w_rd_len[q]  = r_len;
        assign w_rd_wrap[q] = r_wrap;
    end

    // ------------------------------------------------------------------
    // Arbitration: the read pointer only moves when no write competes.
    // ------------------------------------------------------------------
    sdram_rr_arbiter #(.N(NWR)) u_wr_arb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_req   (w_wr_elig),
        .i_adv   (w_grant_ok && w_wr_any),
        .o_gnt   (w_wr_gnt),
        .o_any   (w_wr_any)
    );

    sdram_rr_arbiter #(.N(NRD)) u_rd_arb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_req   (w_rd_elig),
        .i_adv   (w_grant_ok && !w_wr_any && w_rd_any),
        .o_gnt   (w_rd_gnt),
        .o_any   (w_rd_any)
    );

    always_comb begin
        w_gnt_addr = '0;
        w_gnt_len  = '0;
        for (int p = 0; p < NWR; p++) begin
            if (w_wr_any && w_wr_gnt[p]) begin
                w_gnt_addr = w_wr_addr[p];
                w_gnt_len  = w_wr_len[p];
            end
        end
        for (int q = 0; q < NRD; q++) begin
            if (!w_wr_any && w_rd_gnt[q]) begin
                w_gnt_addr = w_rd_addr[q];
                w_gnt_len  = w_rd_len[q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant)        w_state_nxt = ST_REQ;
            ST_REQ:  if (ENG.REQ_ACK)    w_state_nxt = ST_BUSY;
            ST_BUSY: if (ENG.BURST_DONE) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are latched at grant and held until the next grant, so
    // a LOAD on the active port cannot disturb the burst in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_post      <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_len   <= '0;
            r_wr_sel    <= '0;
            r_rd_sel    <= '0;
        end else begin
            r_post <= w_done;
            if (w_grant) begin
                r_req_write <= w_wr_any;
                r_req_addr  <= w_gnt_addr;
                r_req_len   <= w_gnt_len;
                r_wr_sel    <= w_wr_any ? w_wr_gnt : '0;
                r_rd_sel    <= w_wr_any ? '0 : w_rd_gnt;
            end else if (w_done) begin
                r_wr_sel <= '0;
                r_rd_sel <= '0;
            end
        end
    end

    assign ENG.REQ       = (r_state == ST_REQ);
    assign ENG.REQ_WRITE = r_req_write;
    assign ENG.REQ_ADDR  = r_req_addr;
    assign ENG.REQ_LEN   = r_req_len;
    assign WR_SEL        = r_wr_sel;
    assign RD_SEL        = r_rd_sel;
    assign WRAP          = {w_rd_wrap, w_wr_wrap};

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sdram_port_scheduler
//  Purpose : Directed self-checking bench for sdram_port_scheduler
//            (NWR=2, NRD=2, ASIZE=22, LSIZE=9, UWIDTH=9, FIFO_DEPTH=512).
//  Rev     : 1.0  initial multi-port release
// ============================================================================
module tb_sdram_port_scheduler;
    localparam int AW = 22;
    localparam int LW = 9;
    localparam int UW = 9;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic [2*AW-1:0] WR_START_ADDR, WR_MAX_ADDR, RD_START_ADDR, RD_MAX_ADDR;
    logic [2*LW-1:0] WR_LENGTH, RD_LENGTH;
    logic [2*UW-1:0] WR_LEVEL, RD_LEVEL;
    logic [1:0]      WR_LOAD, RD_LOAD, WR_SEL, RD_SEL;
    logic [3:0]      WRAP;

    int checks = 0;
    int errors = 0;

    sdram_port_scheduler_if #(.ASIZE(AW), .LSIZE(LW)) eng ();

    sdram_port_scheduler #(
        .NWR(2), .NRD(2), .ASIZE(AW), .LSIZE(LW), .UWIDTH(UW), .FIFO_DEPTH(512)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .WR_START_ADDR (WR_START_ADDR),
        .WR_MAX_ADDR   (WR_MAX_ADDR),
        .WR_LENGTH     (WR_LENGTH),
        .WR_LOAD       (WR_LOAD),
        .WR_LEVEL      (WR_LEVEL),
        .RD_START_ADDR (RD_START_ADDR),
        .RD_MAX_ADDR   (RD_MAX_ADDR),
        .RD_LENGTH     (RD_LENGTH),
        .RD_LOAD       (RD_LOAD),
        .RD_LEVEL      (RD_LEVEL),
        .WR_SEL        (WR_SEL),
        .RD_SEL        (RD_SEL),
        .WRAP          (WRAP),
        .ENG           (eng)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] start, input logic [AW-1:0] max,
                          input logic [LW-1:0] len, input logic [UW-1:0] lvl);
        WR_START_ADDR[p*AW +: AW] = start;
        WR_MAX_ADDR[p*AW +: AW]   = max;
        WR_LENGTH[p*LW +: LW]     = len;
        WR_LEVEL[p*UW +: UW]      = lvl;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] start, input logic [AW-1:0] max,
                          input logic [LW-1:0] len, input logic [UW-1:0] lvl);
        RD_START_ADDR[p*AW +: AW] = start;
        RD_MAX_ADDR[p*AW +: AW]   = max;
        RD_LENGTH[p*LW +: LW]     = len;
        RD_LEVEL[p*UW +: UW]      = lvl;
    endtask

    task automatic pulse_load(input logic [1:0] wl, input logic [1:0] rl);
        WR_LOAD = wl;
        RD_LOAD = rl;
        tick();
        WR_LOAD = 2'b00;
        RD_LOAD = 2'b00;
    endtask

    // Acts as the burst engine for one burst. Returns in the cycle after
    // BURST_DONE; 'waited' is the number of cycles until REQ was seen.
    task automatic run_burst(input string name, input logic exp_wr, input logic [AW-1:0] exp_addr,
                             input logic [LW-1:0] exp_len, input logic [1:0] exp_wsel,
                             input logic [1:0] exp_rsel, input logic [3:0] exp_wrap,
                             input int ack_dly, input int done_dly, input logic [1:0] done_load,
                             output int waited);
        waited = 0;
        while (eng.REQ !== 1'b1 && waited < 1000) begin
            tick();
            waited++;
        end
        checks++;
        if (eng.REQ !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout: REQ=%b after %0d cycles, required 1", name, eng.REQ, waited);
        end
        checks++;
        if (eng.REQ_WRITE !== exp_wr) begin
            errors++;
            $display("FAIL %s req_write: got %b, required %b", name, eng.REQ_WRITE, exp_wr);
        end
        checks++;
        if (eng.REQ_ADDR !== exp_addr) begin
            errors++;
            $display("FAIL %s req_addr: got %h, required %h", name, eng.REQ_ADDR, exp_addr);
        end
        checks++;
        if (eng.REQ_LEN !== exp_len) begin
            errors++;
            $display("FAIL %s req_len: got %0d, required %0d", name, eng.REQ_LEN, exp_len);
        end
        checks++;
        if ({WR_SEL, RD_SEL} !== {exp_wsel, exp_rsel}) begin
            errors++;
            $display("FAIL %s sel_at_req: got wr=%b rd=%b, required wr=%b rd=%b",
                     name, WR_SEL, RD_SEL, exp_wsel, exp_rsel);
        end
        repeat (ack_dly) tick();
        checks++;
        if (eng.REQ !== 1'b1) begin
            errors++;
            $display("FAIL %s req_hold: got %b, required 1", name, eng.REQ);
        end
        eng.REQ_ACK = 1'b1;
        tick();
        eng.REQ_ACK = 1'b0;
        checks++;
        if (eng.REQ !== 1'b0) begin
            errors++;
            $display("FAIL %s req_drop: got %b, required 0", name, eng.REQ);
        end
        repeat (done_dly) tick();
        eng.BURST_DONE = 1'b1;
        WR_LOAD = done_load;
        checks++;
        if ({WR_SEL, RD_SEL, eng.REQ_ADDR} !== {exp_wsel, exp_rsel, exp_addr}) begin
            errors++;
            $display("FAIL %s done_cycle: got sel=%b%b addr=%h, required sel=%b%b addr=%h",
                     name, WR_SEL, RD_SEL, eng.REQ_ADDR, exp_wsel, exp_rsel, exp_addr);
        end
        tick();
        eng.BURST_DONE = 1'b0;
        WR_LOAD = 2'b00;
        checks++;
        if ({WR_SEL, RD_SEL} !== 4'b0000) begin
            errors++;
            $display("FAIL %s sel_after_done: got wr=%b rd=%b, required 0", name, WR_SEL, RD_SEL);
        end
        checks++;
        if (WRAP !== exp_wrap) begin
            errors++;
            $display("FAIL %s wrap: got %b, required %b", name, WRAP, exp_wrap);
        end
    endtask

    task automatic test_reset();
        logic seen;
        RESET_N = 1'b0;
        WR_START_ADDR = '0; WR_MAX_ADDR = '0; WR_LENGTH = '0; WR_LOAD = '0;
        RD_START_ADDR = '0; RD_MAX_ADDR = '0; RD_LENGTH = '0; RD_LOAD = '0;
        WR_LEVEL = '1; RD_LEVEL = '1;
        eng.REQ_ACK = 1'b0; eng.BURST_DONE = 1'b0;
        repeat (3) tick();
        RESET_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (eng.REQ !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_idle: REQ went %b within 100 cycles, required 0", seen);
        end
        checks++;
        if ({eng.REQ_WRITE, eng.REQ_ADDR, eng.REQ_LEN} !== '0) begin
            errors++;
            $display("FAIL reset_req_fields: got write=%b addr=%h len=%h, required 0",
                     eng.REQ_WRITE, eng.REQ_ADDR, eng.REQ_LEN);
        end
        checks++;
        if ({WR_SEL, RD_SEL, WRAP} !== 8'h00) begin
            errors++;
            $display("FAIL reset_sel_wrap: got %b, required 0", {WR_SEL, RD_SEL, WRAP});
        end
    endtask

    task automatic test_write_rr();
        int w;
        set_wr(0, 22'h000000, 22'h200000, 9'd256, 9'd300);
        set_wr(1, 22'h100000, 22'h200000, 9'd256, 9'd300);
        pulse_load(2'b11, 2'b00);
        run_burst("wr_rr0", 1'b1, 22'h000000, 9'd256, 2'b01, 2'b00, 4'b0000, 2, 270, 2'b00, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL wr_rr0_latency: got %0d, required 1", w);
        end
        run_burst("wr_rr1", 1'b1, 22'h100000, 9'd256, 2'b10, 2'b00, 4'b0000, 2, 270, 2'b00, w);
        checks++;
        if (w !== 2) begin
            errors++;
            $display("FAIL wr_rr1_gap: got %0d, required 2", w);
        end
        run_burst("wr_rr2", 1'b1, 22'h000100, 9'd256, 2'b01, 2'b00, 4'b0000, 2, 270, 2'b00, w);
        run_burst("wr_rr3", 1'b1, 22'h100100, 9'd256, 2'b10, 2'b00, 4'b0000, 2, 270, 2'b00, w);
        set_wr(0, 22'h0, 22'h0, 9'd0, 9'd0);
        set_wr(1, 22'h0, 22'h0, 9'd0, 9'd0);
        pulse_load(2'b11, 2'b00);
    endtask

    task automatic test_read_wrap();
        int w;
        set_rd(0, 22'd10240, 22'd10752, 9'd256, 9'd0);
        pulse_load(2'b00, 2'b01);
        run_burst("rd_wrap0", 1'b0, 22'd10240, 9'd256, 2'b00, 2'b01, 4'b0000, 1, 5, 2'b00, w);
        run_burst("rd_wrap1", 1'b0, 22'd10496, 9'd256, 2'b00, 2'b01, 4'b0100, 1, 5, 2'b00, w);
        run_burst("rd_wrap2", 1'b0, 22'd10240, 9'd256, 2'b00, 2'b01, 4'b0000, 1, 5, 2'b00, w);
        set_rd(0, 22'h0, 22'h0, 9'd0, 9'd0);
        pulse_load(2'b00, 2'b01);
    endtask

    task automatic test_priority();
        int w;
        set_wr(1, 22'h002000, 22'h200000, 9'd16, 9'd300);
        set_rd(1, 22'h003000, 22'h200000, 9'd32, 9'd0);
        pulse_load(2'b10, 2'b10);
        tick();
        // The write is already granted; drop its level so the read wins next.
        WR_LEVEL[1*UW +: UW] = 9'd0;
        run_burst("prio_wr", 1'b1, 22'h002000, 9'd16, 2'b10, 2'b00, 4'b0000, 1, 4, 2'b00, w);
        run_burst("prio_rd", 1'b0, 22'h003000, 9'd32, 2'b00, 2'b10, 4'b0000, 1, 4, 2'b00, w);
        checks++;
        if (w !== 2) begin
            errors++;
            $display("FAIL prio_rd_latency: got %0d, required 2", w);
        end
        set_wr(1, 22'h0, 22'h0, 9'd0, 9'd0);
        set_rd(1, 22'h0, 22'h0, 9'd0, 9'd0);
        pulse_load(2'b10, 2'b10);
    endtask

    task automatic test_read_level();
        int   w;
        logic seen;
        set_rd(0, 22'h000500, 22'h010000, 9'd256, 9'd257);
        pulse_load(2'b00, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (eng.REQ !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rd_level_257: REQ seen=%b, required 0", seen);
        end
        RD_LEVEL[0 +: UW] = 9'd256;
        run_burst("rd_level_256", 1'b0, 22'h000500, 9'd256, 2'b00, 2'b01, 4'b0000, 1, 3, 2'b00, w);
        set_rd(0, 22'h0, 22'h0, 9'd0, 9'd0);
        pulse_load(2'b00, 2'b01);
    endtask

    task automatic test_load_on_done();
        int w;
        set_wr(0, 22'h000040, 22'h000080, 9'd64, 9'd300);
        pulse_load(2'b01, 2'b00);
        tick();
        // Without the LOAD this burst would wrap (0x40+0x40 == max).
        WR_START_ADDR[0 +: AW] = 22'h001000;
        run_burst("ld_done", 1'b1, 22'h000040, 9'd64, 2'b01, 2'b00, 4'b0000, 1, 4, 2'b01, w);
        run_burst("ld_next", 1'b1, 22'h001000, 9'd64, 2'b01, 2'b00, 4'b0001, 1, 4, 2'b00, w);
    endtask

    task automatic test_reset_mid_busy();
        int   waited;
        logic seen;
        set_wr(0, 22'h000300, 22'h200000, 9'd8, 9'd300);
        pulse_load(2'b01, 2'b00);
        waited = 0;
        while (eng.REQ !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (eng.REQ_ADDR !== 22'h000300) begin
            errors++;
            $display("FAIL rst_busy_addr: got %h, required 000300", eng.REQ_ADDR);
        end
        eng.REQ_ACK = 1'b1;
        tick();
        eng.REQ_ACK = 1'b0;
        tick();
        checks++;
        if (WR_SEL !== 2'b01) begin
            errors++;
            $display("FAIL rst_busy_sel_before: got %b, required 01", WR_SEL);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({eng.REQ, eng.REQ_WRITE, WR_SEL, RD_SEL} !== 6'b000000 || eng.REQ_ADDR !== 22'h0) begin
            errors++;
            $display("FAIL rst_busy_clear: got req=%b wr=%b sel=%b%b addr=%h, required all 0",
                     eng.REQ, eng.REQ_WRITE, WR_SEL, RD_SEL, eng.REQ_ADDR);
        end
        tick();
        tick();
        RESET_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (eng.REQ !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_disabled: REQ seen=%b after reset, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write_rr();
        test_read_wrap();
        test_priority();
        test_read_level();
        test_load_on_done();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_scheduler.md
# sdram_port_scheduler

Parametrised multi-port burst scheduler for the SDRAM controller. It replaces the fixed 2-write/2-read, fixed-priority port logic with NWR write ports and NRD read ports, round-robin fairness within each class, and per-port address windows with wrap reporting. It sits between the per-port clock-crossing FIFOs and the SDRAM command/burst engine, all in the CLK (controller) domain.

## Interface
Parameters:
- NWR, 2, number of write ports (1..8)
- NRD, 2, number of read ports (1..8)
- ASIZE, 22, SDRAM word-address width
- LSIZE, 9, burst-length field width
- UWIDTH, 9, FIFO used-word count width
- FIFO_DEPTH, 512, words per read-side FIFO

Ports:
- CLK  in  1  controller clock
- RESET_N  in  1  reset; asynchronous, active-low
- WR_START_ADDR / WR_MAX_ADDR  in  NWR*ASIZE  per-port window start / exclusive end
- WR_LENGTH  in  NWR*LSIZE  per-port burst length
- WR_LOAD  in  NWR  per-port register load
- WR_LEVEL  in  NWR*UWIDTH  words readable in each write FIFO
- RD_START_ADDR, RD_MAX_ADDR, RD_LENGTH, RD_LOAD  in  as the WR_ equivalents, NRD ports
- RD_LEVEL  in  NRD*UWIDTH  words held in each read FIFO (write side)
- REQ  out  1  burst request to the burst engine
- REQ_WRITE  out  1  1 = write burst, 0 = read burst
- REQ_ADDR  out  ASIZE  burst start address
- REQ_LEN  out  LSIZE  burst length
- REQ_ACK  in  1  burst engine accepted the request
- BURST_DONE  in  1  one-cycle pulse, burst finished
- WR_SEL  out  NWR  one-hot; gates the write-FIFO rdreq
- RD_SEL  out  NRD  one-hot; gates the read-FIFO wrreq
- WRAP  out  NWR+NRD  one-cycle pulse per port on window wrap. Bits [NWR-1:0] are write ports, the rest are read ports.

## Operation
- Per-port registers: addr, length. Reset values: all 0. A port with length 0 is disabled.
- LOAD of port p: addr ← START_ADDR[p], length ← LENGTH[p].
  - Port p is ineligible in any cycle its LOAD is high.
  - Other ports are unaffected.
- Eligibility:
  - A write port is eligible when length≠0 and WR_LEVEL ≥ length.
  - A read port is eligible when length≠0 and RD_LEVEL + length ≤ FIFO_DEPTH. Compute this in UWIDTH+1 bits.
- Arbitration:
  - Any eligible write port beats all read ports.
  - Within a class, use round-robin starting from the port after the last grant in that class. The pointer only advances on a grant.
- FSM states:
  - IDLE: if any port is eligible, latch the grant, addr and length, then go to REQ.
  - REQ: REQ=1. On REQ_ACK go to BUSY.
  - BUSY: on BURST_DONE go to IDLE.
- On BURST_DONE, update the granted port: next = addr + length, computed in ASIZE+1 bits.
  - If next < MAX_ADDR: addr ← next.
  - Otherwise: addr ← START_ADDR and pulse WRAP[p].
- If LOAD[p] is high in the same cycle as BURST_DONE for p, the LOAD wins and WRAP is not pulsed.
- LOAD of the granted port during REQ or BUSY does not abort the burst. REQ_ADDR and REQ_LEN stay at their latched values.
- Reset mid-burst returns to IDLE immediately, with all outputs at reset values.

## Timing
- Reset values: REQ=0, REQ_WRITE=0, REQ_ADDR=0, REQ_LEN=0, WR_SEL=0, RD_SEL=0, WRAP=0.
- Grant latency: eligibility is seen in IDLE in cycle n; REQ is high in cycle n+1.
- REQ_ADDR, REQ_LEN and REQ_WRITE are stable from REQ rising until BURST_DONE.
- REQ stays high until the cycle REQ_ACK is sampled high, and is low the next cycle. REQ_ACK while REQ=0 is ignored.
- WR_SEL/RD_SEL are high from the REQ cycle through the BURST_DONE cycle inclusive, and low in the following cycle.
- Address update and WRAP occur in the cycle after BURST_DONE. The FSM is in IDLE that cycle, but this cycle never grants, so there is a minimum of 1 idle cycle between bursts.
- BURST_DONE outside BUSY is ignored.

## Structure
- Package sdram_sched_pkg holds:
  - the state enum (IDLE, REQ, BUSY);
  - the port-index width function clog2;
  - the packed-field slice helpers for the ASIZE/LSIZE/UWIDTH per-port vectors.
- Sub-module sdram_rr_arbiter (parameter N): request vector and advance strobe in, one-hot grant out, round-robin pointer register inside. Instantiate it once for writes and once for reads.

## Test plan
- After reset, no LOAD, all levels at maximum: REQ stays 0 for 100 cycles, and all outputs are at reset values.
- Write ports 0 and 1 loaded with start 0/0x100000, length 256, level 300 on both, ACK after 2 cycles, DONE after 270 cycles:
  - grants alternate 0, 1, 0, 1;
  - REQ_ADDR for port 0 runs 0, 256, 512, ….
- Read port 0 loaded with start 10240, max 10752, length 256, level 0:
  - bursts issue at 10240, then 10496, then wrap to 10240;
  - WRAP[NWR] pulses once on the second DONE.
- Eligible write and read simultaneously: the write is granted first, and the read is granted in the IDLE after that write completes.
- Read level 257 with length 256 and FIFO_DEPTH 512: not eligible. Level 256: granted.
- LOAD of the active port in the BURST_DONE cycle: addr equals the new START_ADDR, and no WRAP pulses. RESET_N low mid-BUSY: REQ and SEL clear immediately.
